// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: field widths, default NOP encoding and the packed IF/ID payload.
package pipe_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle between an upstream stage, the skid register and downstream.
interface pipe_skid_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = INST_W
) ();

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Master drives the stage (upstream producer plus downstream stall/flush control)
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_skid_reg_entry.sv
// One pipeline entry: valid bit plus payload register; clear wins over load.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int              DATA_W  = INST_W,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VAL;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with optional skid entry; define PIPE_SKID_EN to add the skid
// entry and register in_ready, otherwise in_ready is combinational from out_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = INST_W,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_INST)
) (
  input logic          clk,
  input logic          rst,
  pipe_skid_reg_if.slave bus
);

  logic              w_accept;
  logic              w_xfer;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_next;
  logic [DATA_W-1:0] w_main_data;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_xfer   = w_main_valid & bus.out_ready;

`ifdef PIPE_SKID_EN
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;

  // Skid drains into main first; in_ready is low while skid is full so no accept can collide
  always_comb begin
    w_main_load  = 1'b0;
    w_main_next  = bus.in_data;
    w_skid_load  = 1'b0;
    w_skid_clear = bus.flush;
    if (w_xfer && w_skid_valid) begin
      w_main_load  = 1'b1;
      w_main_next  = w_skid_data;
      w_skid_clear = 1'b1;
    end else if (w_accept) begin
      if (!w_main_valid || w_xfer) begin
        w_main_load = 1'b1;
      end else begin
        w_skid_load = 1'b1;
      end
    end
    w_main_clear = bus.flush | (w_xfer & ~w_main_load);
  end

  pipe_entry #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (bus.in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign bus.in_ready = ~w_skid_valid;
`else
  always_comb begin
    w_main_load  = w_accept;
    w_main_next  = bus.in_data;
    w_main_clear = bus.flush | (w_xfer & ~w_accept);
  end

  assign bus.in_ready = ~w_main_valid | bus.out_ready;
`endif

  pipe_entry #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_next),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  assign bus.out_valid = w_main_valid;
  assign bus.out_data  = w_main_valid ? w_main_data : NOP_VAL;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized plus directed bench for pipe_skid_reg against a queue-based occupancy model.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.DATA_W(DW)) bus ();

  pipe_skid_reg #(.DATA_W(DW), .NOP_VAL('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int numChecks = 0;
  int numPassed = 0;

  // Words currently held by the stage, oldest first
  logic [DW-1:0] model[$];

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    numChecks++;
    if (observed === expected) numPassed++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic logic expReady(input logic outReady);
`ifdef PIPE_SKID_EN
    return model.size() < 2;
`else
    return (model.size() == 0) || outReady;
`endif
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge
  task automatic applyStimulus(input logic rstN, input logic flush, input logic inValid,
                               input logic [DW-1:0] inData, input logic outReady);
    logic rdy;
    logic accept;
    logic xfer;
    logic [DW-1:0] expData;
    rst           = rstN;
    bus.flush     = flush;
    bus.in_valid  = inValid;
    bus.in_data   = inData;
    bus.out_ready = outReady;
    @(negedge clk);
    rdy     = expReady(outReady);
    expData = (model.size() > 0) ? model[0] : '0;
    checkOutput("out_valid", DW'(bus.out_valid), DW'(model.size() > 0));
    checkOutput("out_data", bus.out_data, expData);
    checkOutput("in_ready", DW'(bus.in_ready), DW'(rdy));
    @(posedge clk);
    accept = inValid && rdy;
    xfer   = (model.size() > 0) && outReady;
    if (!rstN || flush) begin
      model.delete();
    end else begin
      if (xfer) void'(model.pop_front());
      if (accept) model.push_back(inData);
    end
    #1;
  endtask

  initial begin
    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    model.delete();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Back-to-back streaming
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, DW'(i), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Stall then release
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hC, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Flush with a simultaneous offer
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h6, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h7, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Reset while stalled and full, flush asserted too
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h33, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(99) >= 2), ($urandom_range(99) < 3),
                    ($urandom_range(99) < 70), $urandom, ($urandom_range(99) < 60));
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
